// File: rtl/cpu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, downstream redirect, decode valid/ready.
// Master modport is the fetch stage; slave modport is memory plus decode.
interface cpu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [5:0]  if_opcode;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
    input  imem_ack, imem_rdata, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
    output imem_ack, imem_rdata, redirect, redirect_pc, if_ready
  );
endinterface

// File: rtl/cpu_fetch.sv
// MIPS fetch: one outstanding imem read, BUF_DEPTH-entry instruction FIFO, redirect flush.
// Latency: ack at edge N -> if_valid after edge N; backpressure: FIFO full drops imem_req until a pop.
// Optional CPU_FETCH_JUMP_PREDECODE_EN: follow j/jal targets at fetch instead of PC+4.
module cpu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_fetch_if.master  bus
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_pc;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0] r_buf_pc    [BUF_DEPTH];
  logic [31:0] r_buf_instr [BUF_DEPTH];

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_fetch;
  logic [31:0] w_redir_pc;
  logic [CW-1:0] w_cnt_nxt;
  logic        w_ack;
  logic        w_push;
  logic        w_pop;
  logic        w_space;
  logic        w_unused;

  assign w_unused   = ^bus.redirect_pc[1:0];
  assign w_redir_pc = {bus.redirect_pc[31:2], 2'b00};
  assign w_ack      = bus.imem_ack && r_req;
  assign w_push     = (r_state == REQ) && w_ack && !bus.redirect;
  assign w_pop      = (r_cnt != '0) && bus.if_ready && !bus.redirect;
  assign w_cnt_nxt  = bus.redirect ? '0 : (r_cnt + CW'(w_push) - CW'(w_pop));
  assign w_space    = (w_cnt_nxt < CW'(BUF_DEPTH));
  assign w_pc_seq   = r_pc + 32'd4;

`ifdef CPU_FETCH_JUMP_PREDECODE_EN
  always_comb begin
    w_pc_fetch = w_pc_seq;
    if (bus.imem_rdata[31:26] == 6'd2 || bus.imem_rdata[31:26] == 6'd3)
      w_pc_fetch = {w_pc_seq[31:28], bus.imem_rdata[25:0], 2'b00};
  end
`else
  assign w_pc_fetch = w_pc_seq;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      IDLE: begin
        if (w_space) w_state_nxt = REQ;
      end
      REQ: begin
        if (w_ack) begin
          if (!bus.redirect) w_pc_nxt = w_pc_fetch;
          w_state_nxt = w_space ? REQ : IDLE;
        end else if (bus.redirect) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_ack) w_state_nxt = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Redirect beats both sequential advance and predecoded jumps.
    if (bus.redirect) w_pc_nxt = w_redir_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_req    <= 1'b0;
      r_addr   <= RESET_PC;
      r_pc     <= RESET_PC;
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt != IDLE);
      // r_pc equals r_addr throughout REQ, so reloading while waiting keeps the address stable.
      if (w_state_nxt == REQ) r_addr <= w_pc_nxt;
      r_pc  <= w_pc_nxt;
      r_cnt <= w_cnt_nxt;
      if (bus.redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_pc[i]    <= '0;
        r_buf_instr[i] <= '0;
      end
    end else if (w_push) begin
      r_buf_pc[r_wr_ptr]    <= r_pc;
      r_buf_instr[r_wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_addr;
  assign bus.if_valid  = (r_cnt != '0);
  assign bus.if_instr  = r_buf_instr[r_rd_ptr];
  assign bus.if_pc     = r_buf_pc[r_rd_ptr];
  assign bus.if_opcode = r_buf_instr[r_rd_ptr][31:26];
endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: RESET_PC=0x100, BUF_DEPTH=2, memory returns addr^0xA5A50000
// except a j instruction at jump_addr; ack after wait_states extra cycles.
module tb_cpu_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   ack_cnt = 0;
  int   ack_base;
  logic [3:0]  wait_states;
  logic [3:0]  wc;
  logic [31:0] jump_addr;
  logic [31:0] exp_after_j;

  cpu_fetch_if bus ();

  cpu_fetch #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.imem_ack   = bus.imem_req && (wc == wait_states);
    bus.imem_rdata = (bus.imem_addr == jump_addr) ? 32'h0800_0040
                                                  : (bus.imem_addr ^ 32'hA5A5_0000);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           wc <= '0;
    else if (!bus.imem_req || bus.imem_ack) wc <= '0;
    else                                  wc <= wc + 4'd1;
  end

  always @(posedge clk) begin
    if (rst_n && bus.imem_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
`ifdef CPU_FETCH_JUMP_PREDECODE_EN
    exp_after_j = 32'h0000_0100;
`else
    exp_after_j = 32'h0000_0104;
`endif
    rst_n           = 1'b0;
    wait_states     = 4'd0;
    jump_addr       = 32'hFFFF_FFF0;
    bus.if_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_req",    32'(bus.imem_req),  32'h0);
    chk("rst_addr",   bus.imem_addr,      32'h100);
    chk("rst_valid",  32'(bus.if_valid),  32'h0);
    chk("rst_instr",  bus.if_instr,       32'h0);
    chk("rst_pc",     bus.if_pc,          32'h0);
    chk("rst_opcode", 32'(bus.if_opcode), 32'h0);

    // Zero-wait streaming.
    rst_n = 1'b1;
    step();
    chk("a1_req",   32'(bus.imem_req), 32'h1);
    chk("a1_addr",  bus.imem_addr,     32'h100);
    chk("a1_valid", 32'(bus.if_valid), 32'h0);
    step();
    chk("a2_addr",   bus.imem_addr,      32'h104);
    chk("a2_valid",  32'(bus.if_valid),  32'h1);
    chk("a2_pc",     bus.if_pc,          32'h100);
    chk("a2_instr",  bus.if_instr,       32'hA5A5_0100);
    chk("a2_opcode", 32'(bus.if_opcode), 32'h29);
    step();
    chk("a3_addr", bus.imem_addr, 32'h108);
    chk("a3_pc",   bus.if_pc,     32'h104);

    // Backpressure: FIFO fills, req drops, a single pop yields a single request.
    bus.if_ready = 1'b0;
    step();
    chk("b1_req", 32'(bus.imem_req), 32'h0);
    chk("b1_pc",  bus.if_pc,         32'h104);
    ack_base = ack_cnt;
    step();
    chk("b2_req",  32'(bus.imem_req), 32'h0);
    chk("b2_acks", 32'(ack_cnt - ack_base), 32'h0);
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
    chk("b3_req",  32'(bus.imem_req), 32'h1);
    chk("b3_addr", bus.imem_addr,     32'h10C);
    chk("b3_pc",   bus.if_pc,         32'h108);
    step();
    chk("b4_req",  32'(bus.imem_req), 32'h0);
    chk("b4_acks", 32'(ack_cnt - ack_base), 32'h1);

    // Three wait states.
    bus.if_ready = 1'b1;
    wait_states  = 4'd3;
    step();
    chk("c1_addr", bus.imem_addr, 32'h110);
    chk("c1_pc",   bus.if_pc,     32'h10C);
    step();
    chk("c2_addr",  bus.imem_addr,     32'h110);
    chk("c2_valid", 32'(bus.if_valid), 32'h0);
    step();
    chk("c3_addr", bus.imem_addr, 32'h110);
    step();
    chk("c4_addr", bus.imem_addr,      32'h110);
    chk("c4_ack",  32'(bus.imem_ack),  32'h1);
    step();
    chk("c5_addr",  bus.imem_addr,     32'h114);
    chk("c5_valid", 32'(bus.if_valid), 32'h1);
    chk("c5_pc",    bus.if_pc,         32'h110);
    step();
    chk("c6_valid", 32'(bus.if_valid), 32'h0);

    // Redirect while 0x114 is still waiting: stale data must be dropped.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h2000;
    step();
    bus.redirect = 1'b0;
    chk("d1_addr",  bus.imem_addr,     32'h114);
    chk("d1_req",   32'(bus.imem_req), 32'h1);
    chk("d1_valid", 32'(bus.if_valid), 32'h0);
    step();
    chk("d2_ack", 32'(bus.imem_ack), 32'h1);
    step();
    chk("d3_addr",  bus.imem_addr,     32'h2000);
    chk("d3_valid", 32'(bus.if_valid), 32'h0);
    wait_states = 4'd0;
    step();
    chk("d4_valid", 32'(bus.if_valid), 32'h1);
    chk("d4_pc",    bus.if_pc,         32'h2000);
    chk("d4_instr", bus.if_instr,      32'hA5A5_2000);
    chk("d4_addr",  bus.imem_addr,     32'h2004);

    // Redirect coinciding with ack and pop; low address bits cleared.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h2003;
    step();
    bus.redirect = 1'b0;
    chk("e1_valid", 32'(bus.if_valid), 32'h0);
    chk("e1_addr",  bus.imem_addr,     32'h2000);
    chk("e1_req",   32'(bus.imem_req), 32'h1);
    step();
    chk("e2_valid", 32'(bus.if_valid), 32'h1);
    chk("e2_pc",    bus.if_pc,         32'h2000);

    // From empty with decode stalled: exactly two acks, then idle.
    bus.if_ready    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h3000;
    step();
    bus.redirect = 1'b0;
    ack_base = ack_cnt;
    chk("f1_addr", bus.imem_addr, 32'h3000);
    step();
    chk("f2_addr", bus.imem_addr, 32'h3004);
    step();
    chk("f3_req", 32'(bus.imem_req), 32'h0);
    step();
    chk("f4_req",  32'(bus.imem_req), 32'h0);
    chk("f4_acks", 32'(ack_cnt - ack_base), 32'h2);
    chk("f4_pc",   bus.if_pc, 32'h3000);
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
    chk("f5_addr", bus.imem_addr, 32'h3008);
    chk("f5_pc",   bus.if_pc,     32'h3004);
    step();
    chk("f6_req",  32'(bus.imem_req), 32'h0);
    chk("f6_acks", 32'(ack_cnt - ack_base), 32'h3);

    // Jump at 0x100.
    bus.if_ready    = 1'b1;
    jump_addr       = 32'h100;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 1'b0;
    chk("g1_addr", bus.imem_addr, 32'h100);
    step();
    chk("g2_addr",   bus.imem_addr,      exp_after_j);
    chk("g2_opcode", 32'(bus.if_opcode), 32'h2);
    chk("g2_instr",  bus.if_instr,       32'h0800_0040);

    // Async reset abandons the outstanding request immediately.
    chk("h0_req", 32'(bus.imem_req), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("h1_req",   32'(bus.imem_req), 32'h0);
    chk("h1_valid", 32'(bus.if_valid), 32'h0);
    chk("h1_addr",  bus.imem_addr,     32'h100);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
